io_decomp_ctrl: RTL and testbench

Sequencing controller for the IO module's four byte-lane decompressors: lane 0 = A, lane 1 = B, lane 2 = U, lane 3 = rest. Each lane takes one byte of the shared 32-bit input word.

- Decides when the decompressors start and which lanes are still consuming words.
- Decides when the load phase is complete.
- Hands off to the coordinator for the calculate phase and waits for it to report `ready`.
- Sits between the host interrupt/data interface and the decompressor and coordinator blocks.

---
 rtl/io_pkg.sv | 16 +
 rtl/io_decomp_ctrl_if.sv | 25 ++
 rtl/adder.sv | 10 +
 rtl/io_decomp_ctrl.sv | 145 ++++++++++++++
 tb/tb_io_decomp_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the IO module: controller state encoding and byte-lane indices.
package io_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE     = 2'b00;
  localparam state_t DECOMP   = 2'b01;
  localparam state_t WAIT_CMD = 2'b10;
  localparam state_t CALC     = 2'b11;

  localparam int LANE_A = 0;
  localparam int LANE_B = 1;
  localparam int LANE_U = 2;
  localparam int LANE_R = 3;

endpackage

// File: rtl/io_decomp_ctrl_if.sv
// Host/decompressor/coordinator signals around the IO decompression controller.
interface io_decomp_ctrl_if;
  logic       int_req;
  logic       process;
  logic       wvalid;
  logic [3:0] eob;
  logic       ready;
  logic [3:0] start;
  logic [3:0] lane_en;
  logic       next;
  logic [3:0] finish;
  logic       calc_start;
  logic       done;
  logic       busy;

  modport master (
    output int_req, process, wvalid, eob, ready,
    input  start, lane_en, next, finish, calc_start, done, busy
  );

  modport slave (
    input  int_req, process, wvalid, eob, ready,
    output start, lane_en, next, finish, calc_start, done, busy
  );
endinterface

// File: rtl/adder.sv
// Parameterised unsigned adder; the sum wraps at WIDTH bits.
module adder #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/io_decomp_ctrl.sv
// Sequences the four byte-lane decompressors through load, then hands off to the
// coordinator for the calculate phase. All outputs come straight from flops.
module io_decomp_ctrl
  import io_pkg::*;
#(
  parameter int REST_OBJS = 2
) (
  input logic              clk,
  input logic              reset,
  io_decomp_ctrl_if.slave  bus
);

  localparam logic [1:0] REST_TARGET = 2'(REST_OBJS);

  state_t     state_q, state_d;
  logic [3:0] start_q, start_d;
  logic [3:0] lane_en_q, lane_en_d;
  logic [3:0] finish_q, finish_d;
  logic       next_q, next_d;
  logic       calc_start_q, calc_start_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic [1:0] rest_cnt_q, rest_cnt_d;
  logic       calc_pending_q, calc_pending_d;
  logic [1:0] rest_sum;
  logic       calc_req;
  logic       load_req;
  logic       pending_now;

  adder #(2) u_rest_add (
    .a   (rest_cnt_q),
    .b   (2'd1),
    .sum (rest_sum)
  );

  assign calc_req = bus.int_req & bus.process;
  assign load_req = bus.int_req & ~bus.process;

  always_comb begin
    state_d        = state_q;
    start_d        = 4'b0000;
    lane_en_d      = lane_en_q;
    finish_d       = finish_q;
    next_d         = 1'b0;
    calc_start_d   = 1'b0;
    done_d         = 1'b0;
    rest_cnt_d     = rest_cnt_q;
    calc_pending_d = calc_pending_q;
    pending_now    = calc_pending_q;

    case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d        = DECOMP;
          finish_d       = 4'b0000;
          rest_cnt_d     = 2'd0;
          calc_pending_d = 1'b0;
          start_d        = 4'b1111;
          lane_en_d      = 4'b1111;
        end
      end

      DECOMP: begin
        next_d = bus.wvalid && (lane_en_q != 4'b0000);
        for (int i = LANE_A; i <= LANE_U; i++) begin
          if (bus.eob[i] && !finish_q[i]) begin
            finish_d[i]  = 1'b1;
            lane_en_d[i] = 1'b0;
          end
        end
        // The rest lane closes only after REST_OBJS objects; once closed it no longer counts.
        if (bus.eob[LANE_R] && !finish_q[LANE_R]) begin
          rest_cnt_d = rest_sum;
          if (rest_sum == REST_TARGET) begin
            finish_d[LANE_R]  = 1'b1;
            lane_en_d[LANE_R] = 1'b0;
          end
        end
        pending_now    = calc_pending_q | calc_req;
        calc_pending_d = pending_now;
        if (finish_d == 4'b1111) begin
          if (pending_now) begin
            state_d      = CALC;
            calc_start_d = 1'b1;
          end else begin
            state_d = WAIT_CMD;
          end
        end
      end

      WAIT_CMD: begin
        if (calc_req) begin
          state_d      = CALC;
          calc_start_d = 1'b1;
        end
      end

      CALC: begin
        if (bus.ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      start_q        <= 4'b0000;
      lane_en_q      <= 4'b0000;
      finish_q       <= 4'b0000;
      next_q         <= 1'b0;
      calc_start_q   <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      rest_cnt_q     <= 2'd0;
      calc_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_q        <= start_d;
      lane_en_q      <= lane_en_d;
      finish_q       <= finish_d;
      next_q         <= next_d;
      calc_start_q   <= calc_start_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
      rest_cnt_q     <= rest_cnt_d;
      calc_pending_q <= calc_pending_d;
    end
  end

  assign bus.start      = start_q;
  assign bus.lane_en    = lane_en_q;
  assign bus.finish     = finish_q;
  assign bus.next       = next_q;
  assign bus.calc_start = calc_start_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_io_decomp_ctrl.sv
// Self-checking bench for io_decomp_ctrl: directed vector table, hand-written corner
// sequences, then randomized traffic against a phase/counter reference model.
module tb_io_decomp_ctrl;

  localparam int REST = 2;

  logic clk;
  logic reset;

  io_decomp_ctrl_if bus ();

  io_decomp_ctrl #(.REST_OBJS(REST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       intr;
    logic       proc;
    logic       wv;
    logic       rdy;
    logic [3:0] eob;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  // Expected output vector layout: {start, lane_en, finish, next, calc_start, done, busy}
  function automatic logic [15:0] pk(logic [3:0] st, logic [3:0] len, logic [3:0] fin,
                                     logic nx, logic cs, logic dn, logic bz);
    return {st, len, fin, nx, cs, dn, bz};
  endfunction

  task automatic addRow(logic rst, logic intr, logic proc, logic wv, logic rdy, logic [3:0] eob,
                        logic [3:0] st, logic [3:0] len, logic [3:0] fin,
                        logic nx, logic cs, logic dn, logic bz);
    vec_t v;
    v.rst = rst; v.intr = intr; v.proc = proc; v.wv = wv; v.rdy = rdy; v.eob = eob;
    v.exp = pk(st, len, fin, nx, cs, dn, bz);
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(logic rst, logic intr, logic proc, logic wv, logic rdy,
                               logic [3:0] eob);
    reset       = rst;
    bus.int_req = intr;
    bus.process = proc;
    bus.wvalid  = wv;
    bus.ready   = rdy;
    bus.eob     = eob;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string name, logic [15:0] exp);
    logic [15:0] act;
    act = {bus.start, bus.lane_en, bus.finish, bus.next, bus.calc_start, bus.done, bus.busy};
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h (st/len/fin/nx,cs,dn,bz) required %h", name, act, exp);
  endtask

  // Reference model: tracks load phase and objects seen per lane, not RTL state bits.
  typedef enum {M_IDLE, M_LOAD, M_WAIT, M_CALC} mphase_t;
  mphase_t m_ph;
  int      m_cnt[4];
  bit      m_pend;

  function automatic int lane_target(int i);
    return (i == 3) ? REST : 1;
  endfunction

  function automatic bit lane_done(int i);
    return m_cnt[i] >= lane_target(i);
  endfunction

  function automatic bit all_done();
    return lane_done(0) && lane_done(1) && lane_done(2) && lane_done(3);
  endfunction

  task automatic modelStep(logic rst, logic intr, logic proc, logic wv, logic rdy,
                           logic [3:0] eob, output logic [15:0] exp);
    logic [3:0] st = 4'b0000;
    logic [3:0] fin;
    logic [3:0] len;
    bit nx = 0, cs = 0, dn = 0;
    if (rst) begin
      m_ph = M_IDLE;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_pend = 0;
    end else begin
      case (m_ph)
        M_IDLE: if (intr && !proc) begin
          m_ph = M_LOAD;
          for (int i = 0; i < 4; i++) m_cnt[i] = 0;
          m_pend = 0;
          st = 4'b1111;
        end
        M_LOAD: begin
          nx = wv && !all_done();
          for (int i = 0; i < 4; i++)
            if (eob[i] && !lane_done(i)) m_cnt[i]++;
          if (intr && proc) m_pend = 1;
          if (all_done()) begin
            if (m_pend) begin m_ph = M_CALC; cs = 1; end
            else m_ph = M_WAIT;
          end
        end
        M_WAIT: if (intr && proc) begin m_ph = M_CALC; cs = 1; end
        M_CALC: if (rdy) begin m_ph = M_IDLE; dn = 1; end
        default: m_ph = M_IDLE;
      endcase
    end
    for (int i = 0; i < 4; i++) fin[i] = lane_done(i);
    len = (m_ph == M_LOAD) ? ~fin : 4'b0000;
    exp = pk(st, len, fin, nx, cs, dn, m_ph != M_IDLE);
  endtask

  initial begin
    logic [15:0] e;
    logic r_rst, r_int, r_proc, r_wv, r_rdy;
    logic [3:0] r_eob;

    reset = 1'b1; bus.int_req = 0; bus.process = 0; bus.wvalid = 0; bus.ready = 0; bus.eob = 0;

    // Basic load/calculate, word acknowledge, repeated/simultaneous eob, ignored inputs.
    addRow(1,0,0,0,0,4'h0, 4'h0,4'h0,4'h0, 0,0,0,0);
    addRow(0,1,0,0,0,4'h0, 4'hF,4'hF,4'h0, 0,0,0,1);
    addRow(0,0,0,0,0,4'h1, 4'h0,4'hE,4'h1, 0,0,0,1);
    addRow(0,0,0,0,0,4'h2, 4'h0,4'hC,4'h3, 0,0,0,1);
    addRow(0,0,0,0,0,4'h4, 4'h0,4'h8,4'h7, 0,0,0,1);
    addRow(0,0,0,0,0,4'h8, 4'h0,4'h8,4'h7, 0,0,0,1);
    addRow(0,0,0,0,0,4'h8, 4'h0,4'h0,4'hF, 0,0,0,1);
    addRow(0,1,1,0,0,4'h0, 4'h0,4'h0,4'hF, 0,1,0,1);
    addRow(0,0,0,0,0,4'h0, 4'h0,4'h0,4'hF, 0,0,0,1);
    addRow(0,0,0,0,1,4'h0, 4'h0,4'h0,4'hF, 0,0,1,0);
    addRow(0,0,0,0,0,4'h0, 4'h0,4'h0,4'hF, 0,0,0,0);
    addRow(0,1,0,0,0,4'h0, 4'hF,4'hF,4'h0, 0,0,0,1);
    for (int i = 0; i < 6; i++) addRow(0,0,0,1,0,4'h0, 4'h0,4'hF,4'h0, 1,0,0,1);
    addRow(0,0,0,0,0,4'h0, 4'h0,4'hF,4'h0, 0,0,0,1);
    addRow(0,0,0,0,0,4'hF, 4'h0,4'h8,4'h7, 0,0,0,1);
    addRow(0,0,0,0,0,4'hF, 4'h0,4'h0,4'hF, 0,0,0,1);
    addRow(0,0,0,0,0,4'h1, 4'h0,4'h0,4'hF, 0,0,0,1);
    addRow(0,1,0,0,0,4'h0, 4'h0,4'h0,4'hF, 0,0,0,1);
    addRow(0,1,1,0,0,4'h0, 4'h0,4'h0,4'hF, 0,1,0,1);
    addRow(0,1,0,0,0,4'h0, 4'h0,4'h0,4'hF, 0,0,0,1);
    addRow(0,0,0,0,0,4'hF, 4'h0,4'h0,4'hF, 0,0,0,1);
    addRow(0,0,0,0,1,4'h0, 4'h0,4'h0,4'hF, 0,0,1,0);
    addRow(0,1,1,0,0,4'h0, 4'h0,4'h0,4'hF, 0,0,0,0);
    addRow(0,0,0,0,0,4'hF, 4'h0,4'h0,4'hF, 0,0,0,0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].intr, vecs[i].proc, vecs[i].wv, vecs[i].rdy, vecs[i].eob);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Early calculate: request while lane 3 still counting goes straight to CALC.
    applyStimulus(1,0,0,0,0,4'h0); checkOutput("early_rst",   pk(4'h0,4'h0,4'h0,0,0,0,0));
    applyStimulus(0,1,0,0,0,4'h0); checkOutput("early_load",  pk(4'hF,4'hF,4'h0,0,0,0,1));
    applyStimulus(0,0,0,0,0,4'h7); checkOutput("early_0111",  pk(4'h0,4'h8,4'h7,0,0,0,1));
    applyStimulus(0,1,1,0,0,4'h0); checkOutput("early_req",   pk(4'h0,4'h8,4'h7,0,0,0,1));
    applyStimulus(0,0,0,0,0,4'h8); checkOutput("early_r1",    pk(4'h0,4'h8,4'h7,0,0,0,1));
    applyStimulus(0,0,0,0,0,4'h8); checkOutput("early_r2",    pk(4'h0,4'h0,4'hF,0,1,0,1));
    applyStimulus(0,0,0,0,0,4'h0); checkOutput("early_calc",  pk(4'h0,4'h0,4'hF,0,0,0,1));
    applyStimulus(0,1,1,0,0,4'h0); checkOutput("early_ign",   pk(4'h0,4'h0,4'hF,0,0,0,1));
    applyStimulus(0,0,0,0,1,4'h0); checkOutput("early_done",  pk(4'h0,4'h0,4'hF,0,0,1,0));

    // Reset mid-load, clean restart, last eob coinciding with the calculate request.
    applyStimulus(0,1,0,0,0,4'h0); checkOutput("rst_load",    pk(4'hF,4'hF,4'h0,0,0,0,1));
    applyStimulus(0,0,0,0,0,4'h3); checkOutput("rst_0011",    pk(4'h0,4'hC,4'h3,0,0,0,1));
    applyStimulus(1,0,0,1,0,4'h4); checkOutput("rst_mid",     pk(4'h0,4'h0,4'h0,0,0,0,0));
    applyStimulus(0,1,0,0,0,4'h0); checkOutput("rst_reload",  pk(4'hF,4'hF,4'h0,0,0,0,1));
    applyStimulus(0,0,0,0,0,4'h7); checkOutput("rst_0111",    pk(4'h0,4'h8,4'h7,0,0,0,1));
    applyStimulus(0,0,0,0,0,4'h8); checkOutput("rst_r1",      pk(4'h0,4'h8,4'h7,0,0,0,1));
    applyStimulus(0,1,1,0,0,4'h8); checkOutput("rst_simul",   pk(4'h0,4'h0,4'hF,0,1,0,1));
    applyStimulus(0,0,0,0,1,4'h0); checkOutput("rst_done",    pk(4'h0,4'h0,4'hF,0,0,1,0));

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      r_rst  = (n == 0) || ($urandom_range(0, 99) == 0);
      r_int  = ($urandom_range(0, 4) == 0);
      r_proc = 1'($urandom_range(0, 1));
      r_wv   = 1'($urandom_range(0, 1));
      r_rdy  = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < 4; b++) r_eob[b] = ($urandom_range(0, 3) == 0);
      modelStep(r_rst, r_int, r_proc, r_wv, r_rdy, r_eob, e);
      applyStimulus(r_rst, r_int, r_proc, r_wv, r_rdy, r_eob);
      checkOutput($sformatf("rand%0d", n), e);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
